grid_avalon_reader: RTL

Avalon-MM slave that gives the Nios processor a coherent, read-only view of the game state produced by `tetris_grid`. `tetris_grid` writes the 200-bit `grid_state`, the score and the status flags; this block snapshots them on request and serves them as 32-bit words to the LCD rendering software. It sits between `tetris_grid` and the `grid_interface` conduit of the `tetris` system. It also tracks grid changes and row clears so software redraws only when needed.

---
 rtl/grid_avalon_reader_if.sv | 25 ++
 rtl/grid_avalon_reader.sv | 126 ++++++++++++
 2 files changed

// File: rtl/grid_avalon_reader_if.sv
// Avalon-MM slave bus bundle for grid_avalon_reader (word addressed, fixed read latency 1).
`timescale 1ns/1ps
interface grid_avalon_reader_if;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );
endinterface

// File: rtl/grid_avalon_reader.sv
// Snapshot reader for the tetris_grid game state, served as 32-bit Avalon-MM words.
// Define GRID_IRQ_EN to add the irq output and the CONTROL[2] irq_en bit.
`timescale 1ns/1ps
module grid_avalon_reader (
  input  logic                 clk,
  input  logic                 reset_n,
  grid_avalon_reader_if.slave  avs,
  input  logic [199:0]         grid_state,
  input  logic [13:0]          score,
  input  logic                 game_over,
  input  logic                 game_paused,
  input  logic                 row_cleared
`ifdef GRID_IRQ_EN
  ,
  output logic                 irq
`endif
);

  // Bus protocol: no waitrequest. A read sampled at an edge is answered on
  // avs_readdata after that edge; a write takes effect at the edge it is
  // sampled. A read and a write in the same cycle: read served, write dropped.

  localparam logic [4:0] ADDR_STATUS  = 5'd0;
  localparam logic [4:0] ADDR_SCORE   = 5'd1;
  localparam logic [4:0] ADDR_CONTROL = 5'd2;

  logic [199:0] snap;
  logic [13:0]  snap_score;
  logic [199:0] prev_grid;
  logic         snap_valid;
  logic         changed;
  logic         row_sticky;
  logic [15:0]  snap_count;
  logic [31:0]  rdata_q;

  logic         wr_en;
  logic         ctrl_wr;
  logic         snap_req;
  logic         clr_row;
  logic         grid_diff;
  logic [31:0]  status_word;
  logic [31:0]  control_word;
  logic [31:0]  rd_mux;
  logic         unused_wd;

  assign unused_wd = &{1'b0, avs.avs_writedata[31:2]};

  always_comb begin
    wr_en       = avs.avs_write & ~avs.avs_read;
    ctrl_wr     = wr_en & (avs.avs_address == ADDR_CONTROL);
    snap_req    = ctrl_wr & avs.avs_writedata[0];
    clr_row     = ctrl_wr & avs.avs_writedata[1];
    grid_diff   = (grid_state != prev_grid);
    status_word = {snap_count, 11'b0, row_sticky, changed, snap_valid,
                   game_paused, game_over};
  end

`ifdef GRID_IRQ_EN
  logic irq_en;

  always_comb begin
    control_word = {29'b0, irq_en, 2'b00};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= avs.avs_writedata[2];
      irq <= changed & irq_en;
    end
  end
`else
  always_comb begin
    control_word = 32'b0;
  end
`endif

  always_comb begin
    rd_mux = 32'b0;
    case (avs.avs_address)
      ADDR_STATUS:  rd_mux = status_word;
      ADDR_SCORE:   rd_mux = {18'b0, snap_score};
      ADDR_CONTROL: rd_mux = control_word;
      5'd4:         rd_mux = snap[31:0];
      5'd5:         rd_mux = snap[63:32];
      5'd6:         rd_mux = snap[95:64];
      5'd7:         rd_mux = snap[127:96];
      5'd8:         rd_mux = snap[159:128];
      5'd9:         rd_mux = snap[191:160];
      5'd10:        rd_mux = {24'b0, snap[199:192]};
      default:      rd_mux = 32'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap       <= '0;
      snap_score <= '0;
      prev_grid  <= '0;
      snap_valid <= 1'b0;
      changed    <= 1'b0;
      row_sticky <= 1'b0;
      snap_count <= '0;
      rdata_q    <= '0;
    end else begin
      prev_grid <= grid_state;
      if (snap_req) begin
        snap       <= grid_state;
        snap_score <= score;
        snap_valid <= 1'b1;
        snap_count <= snap_count + 16'd1;
      end
      // A change seen on the snapshot edge is already captured, so clear wins.
      if (snap_req)       changed <= 1'b0;
      else if (grid_diff) changed <= 1'b1;
      if (row_cleared)    row_sticky <= 1'b1;
      else if (clr_row)   row_sticky <= 1'b0;
      if (avs.avs_read)   rdata_q <= rd_mux;
    end
  end

  assign avs.avs_readdata = rdata_q;

endmodule
